// File: rtl/zap_wb_arbiter_if.sv
// Wishbone B3 bus bundle used by zap_wb_arbiter.
//   master modport : drives cyc/stb/we/adr/dat_w/sel/cti, receives dat_r/ack/err
//   slave modport  : the mirror image
// dat_w carries master-to-slave write data, dat_r carries slave-to-master read data.
interface zap_wb_arbiter_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel, cti,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel, cti,
    output dat_r, ack, err
  );
endinterface

// File: rtl/zap_wb_arbiter.sv
// Two-master, one-slave Wishbone B3 arbiter (m0 = instruction fetch, m1 = data).
// Round-robin between simultaneous requests, the winner keeps the bus for the
// whole CYC period so bursts are never split, and a per-transfer ack timeout
// terminates a hung transfer with ERR.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   m0, m1         : master-side buses (slave modport of the bundle)
//   s              : slave-side bus (master modport); s.err is not consumed
//   o_gnt          : one-hot grant, 01 = m0, 10 = m1, 00 = idle (registered)
module zap_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  zap_wb_arbiter_if.slave        m0,
  zap_wb_arbiter_if.slave        m1,
  zap_wb_arbiter_if.master       s,
  output logic [1:0]             o_gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;  // 0 = m0, 1 = m1
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        gnt0, gnt1, granted;
  logic        g_cyc, g_stb, g_we;
  logic [31:0] g_adr, g_dat;
  logic [3:0]  g_sel;
  logic [2:0]  g_cti;
  logic        timeout_hit;
  logic        ack_fwd;
  logic        req0, req1;

  assign gnt0    = (state_q == GNT0);
  assign gnt1    = (state_q == GNT1);
  assign granted = gnt0 | gnt1;
  assign req0    = m0.cyc & m0.stb;
  assign req1    = m1.cyc & m1.stb;

  // Granted master's request, zeroed while idle.
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_cti = '0;
    if (gnt0) begin
      g_cyc = m0.cyc;
      g_stb = m0.stb;
      g_we  = m0.we;
      g_adr = m0.adr;
      g_dat = m0.dat_w;
      g_sel = m0.sel;
      g_cti = m0.cti;
    end else if (gnt1) begin
      g_cyc = m1.cyc;
      g_stb = m1.stb;
      g_we  = m1.we;
      g_adr = m1.adr;
      g_dat = m1.dat_w;
      g_sel = m1.sel;
      g_cti = m1.cti;
    end
  end

  // A real ack always wins over the timeout on the same cycle.
  assign timeout_hit = TO_EN && granted && g_cyc && g_stb && !s.ack && (cnt_q == CNT_LAST);
  // Acks are only forwarded while the owner still holds CYC.
  assign ack_fwd     = granted && g_cyc && s.ack;

  always_comb begin
    s.cyc   = g_cyc & ~timeout_hit;
    s.stb   = g_stb & ~timeout_hit;
    s.we    = g_we;
    s.adr   = g_adr;
    s.dat_w = g_dat;
    s.sel   = g_sel;
    s.cti   = g_cti;

    m0.ack   = gnt0 & ack_fwd;
    m0.err   = gnt0 & timeout_hit;
    m0.dat_r = gnt0 ? s.dat_r : '0;
    m1.ack   = gnt1 & ack_fwd;
    m1.err   = gnt1 & timeout_hit;
    m1.dat_r = gnt1 ? s.dat_r : '0;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = '0;
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_grant_q)) begin
          state_d      = GNT0;
          last_grant_d = 1'b0;
        end else if (req1) begin
          state_d      = GNT1;
          last_grant_d = 1'b1;
        end
      end
      GNT0, GNT1: begin
        // Bus is locked until CYC falls; only the timeout can break the lock.
        if (!g_cyc || timeout_hit) begin
          state_d = IDLE;
        end else if (g_stb && !s.ack) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_gnt = {gnt1, gnt0};

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// Bench for zap_wb_arbiter with an 8-cycle ack timeout. Inputs are driven on
// the falling edge, the expected record is queued, and outputs are compared
// 1 ns later against the popped record.
module tb_zap_wb_arbiter;

  localparam logic        L    = 1'b0;
  localparam logic        H    = 1'b1;
  localparam logic [1:0]  G_ID = 2'b00;
  localparam logic [1:0]  G_M0 = 2'b01;
  localparam logic [1:0]  G_M1 = 2'b10;
  localparam logic [31:0] Z    = 32'h0;
  localparam logic [31:0] A_M0 = 32'h0000_0100;
  localparam logic [31:0] A_M1 = 32'h0000_0200;
  localparam logic [2:0]  C0   = 3'b000;
  localparam logic [2:0]  CI   = 3'b010;
  localparam logic [2:0]  CE   = 3'b111;

  typedef struct {
    // stimulus
    logic        rst, m0c, m0s, m1c, m1s, sack;
    logic [31:0] sdat;
    logic [31:0] m1adr;
    logic [2:0]  m1cti;
    // expected
    logic [1:0]  gnt;
    logic        scyc, sstb;
    logic [31:0] sadr;
    logic [2:0]  scti;
    logic        m0ack, m0err;
    logic [31:0] m0dat;
    logic        m1ack, m1err;
    logic [31:0] m1dat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;
  int         errors = 0;
  int         checks = 0;
  vec_t       exp_q[$];
  vec_t       tbl[24];
  vec_t       cur;

  zap_wb_arbiter_if m0_bus();
  zap_wb_arbiter_if m1_bus();
  zap_wb_arbiter_if s_bus();

  zap_wb_arbiter #(
    .TIMEOUT_CYCLES(8),
    .CNT_W(16)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .m0     (m0_bus),
    .m1     (m1_bus),
    .s      (s_bus),
    .o_gnt  (gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    rst          = v.rst;
    m0_bus.cyc   = v.m0c;
    m0_bus.stb   = v.m0s;
    m1_bus.cyc   = v.m1c;
    m1_bus.stb   = v.m1s;
    m1_bus.adr   = v.m1adr;
    m1_bus.cti   = v.m1cti;
    s_bus.ack    = v.sack;
    s_bus.dat_r  = v.sdat;
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    chk({tag, " gnt"},    {30'd0, gnt},          {30'd0, e.gnt});
    chk({tag, " s_cyc"},  {31'd0, s_bus.cyc},    {31'd0, e.scyc});
    chk({tag, " s_stb"},  {31'd0, s_bus.stb},    {31'd0, e.sstb});
    chk({tag, " s_adr"},  s_bus.adr,             e.sadr);
    chk({tag, " s_cti"},  {29'd0, s_bus.cti},    {29'd0, e.scti});
    chk({tag, " m0_ack"}, {31'd0, m0_bus.ack},   {31'd0, e.m0ack});
    chk({tag, " m0_err"}, {31'd0, m0_bus.err},   {31'd0, e.m0err});
    chk({tag, " m0_dat"}, m0_bus.dat_r,          e.m0dat);
    chk({tag, " m1_ack"}, {31'd0, m1_bus.ack},   {31'd0, e.m1ack});
    chk({tag, " m1_err"}, {31'd0, m1_bus.err},   {31'd0, e.m1err});
    chk({tag, " m1_dat"}, m1_bus.dat_r,          e.m1dat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Fields: rst,m0c,m0s,m1c,m1s,sack,sdat,m1adr,m1cti |
    //         gnt,scyc,sstb,sadr,scti, m0ack,m0err,m0dat, m1ack,m1err,m1dat
    // Single-master read with ack on the fourth granted cycle.
    tbl[0]  = '{H,L,L,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0,    L,L,Z, L,L,Z};
    tbl[1]  = '{L,H,H,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0,    L,L,Z, L,L,Z};
    tbl[2]  = '{L,H,H,L,L,L,Z,A_M1,C0, G_M0,H,H,A_M0,C0, L,L,Z, L,L,Z};
    tbl[3]  = '{L,H,H,L,L,L,Z,A_M1,C0, G_M0,H,H,A_M0,C0, L,L,Z, L,L,Z};
    tbl[4]  = '{L,H,H,L,L,L,Z,A_M1,C0, G_M0,H,H,A_M0,C0, L,L,Z, L,L,Z};
    tbl[5]  = '{L,H,H,L,L,H,32'hDEADBEEF,A_M1,C0, G_M0,H,H,A_M0,C0, H,L,32'hDEADBEEF, L,L,Z};
    tbl[6]  = '{L,L,L,L,L,L,Z,A_M1,C0, G_M0,L,L,A_M0,C0, L,L,Z, L,L,Z};
    tbl[7]  = '{L,L,L,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0,    L,L,Z, L,L,Z};
    // Tie after m0 was last granted: m1 wins, then a bubble, then m0.
    tbl[8]  = '{L,H,H,H,H,L,Z,A_M1,C0, G_ID,L,L,Z,C0,    L,L,Z, L,L,Z};
    tbl[9]  = '{L,H,H,H,H,L,Z,A_M1,C0, G_M1,H,H,A_M1,C0, L,L,Z, L,L,Z};
    tbl[10] = '{L,H,H,L,L,L,Z,A_M1,C0, G_M1,L,L,A_M1,C0, L,L,Z, L,L,Z};
    tbl[11] = '{L,H,H,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0,    L,L,Z, L,L,Z};
    tbl[12] = '{L,H,H,L,L,L,Z,A_M1,C0, G_M0,H,H,A_M0,C0, L,L,Z, L,L,Z};
    tbl[13] = '{L,L,L,L,L,L,Z,A_M1,C0, G_M0,L,L,A_M0,C0, L,L,Z, L,L,Z};
    tbl[14] = '{L,L,L,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0,    L,L,Z, L,L,Z};
    // Reset restores m0 as tie winner.
    tbl[15] = '{H,H,H,H,H,L,Z,A_M1,C0, G_ID,L,L,Z,C0,    L,L,Z, L,L,Z};
    tbl[16] = '{L,H,H,H,H,L,Z,A_M1,C0, G_ID,L,L,Z,C0,    L,L,Z, L,L,Z};
    tbl[17] = '{L,H,H,H,H,L,Z,A_M1,C0, G_M0,H,H,A_M0,C0, L,L,Z, L,L,Z};
    tbl[18] = '{L,L,L,H,H,L,Z,A_M1,C0, G_M0,L,L,A_M0,C0, L,L,Z, L,L,Z};
    tbl[19] = '{L,L,L,H,H,L,Z,A_M1,C0, G_ID,L,L,Z,C0,    L,L,Z, L,L,Z};
    tbl[20] = '{L,L,L,H,H,L,Z,A_M1,C0, G_M1,H,H,A_M1,C0, L,L,Z, L,L,Z};
    tbl[21] = '{L,L,L,L,L,L,Z,A_M1,C0, G_M1,L,L,A_M1,C0, L,L,Z, L,L,Z};
    tbl[22] = '{L,L,L,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0,    L,L,Z, L,L,Z};
    // Stray ack while idle is not forwarded.
    tbl[23] = '{L,L,L,L,L,H,32'hAAAA5555,A_M1,C0, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};

    rst          = 1'b1;
    m0_bus.cyc   = 1'b0;
    m0_bus.stb   = 1'b0;
    m0_bus.we    = 1'b0;
    m0_bus.adr   = A_M0;
    m0_bus.dat_w = 32'h1111_1111;
    m0_bus.sel   = 4'hF;
    m0_bus.cti   = C0;
    m1_bus.cyc   = 1'b0;
    m1_bus.stb   = 1'b0;
    m1_bus.we    = 1'b1;
    m1_bus.adr   = A_M1;
    m1_bus.dat_w = 32'h2222_2222;
    m1_bus.sel   = 4'hF;
    m1_bus.cti   = C0;
    s_bus.ack    = 1'b0;
    s_bus.err    = 1'b0;
    s_bus.dat_r  = Z;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 24; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Burst lock: m1 runs 4 beats while m0 requests throughout.
    cur = '{L,L,L,H,H,L,Z,A_M1,CI, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};
    run(cur, "burst_req");
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  c;
      a = A_M1 + 32'(4 * i);
      d = 32'h1000 + 32'(i);
      c = (i == 3) ? CE : CI;
      cur = '{L,H,H,H,H,H,d,a,c, G_M1,H,H,a,c, L,L,Z, H,L,d};
      run(cur, $sformatf("burst_beat%0d", i));
    end
    cur = '{L,H,H,H,L,L,Z,32'h20C,CE, G_M1,H,L,32'h20C,CE, L,L,Z, L,L,Z};
    run(cur, "burst_hold");
    cur = '{L,H,H,L,L,L,Z,32'h20C,CE, G_M1,L,L,32'h20C,CE, L,L,Z, L,L,Z};
    run(cur, "burst_drop");
    cur = '{L,H,H,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};
    run(cur, "burst_bubble");
    cur = '{L,H,H,L,L,L,Z,A_M1,C0, G_M0,H,H,A_M0,C0, L,L,Z, L,L,Z};
    run(cur, "burst_m0gnt");
    cur = '{L,L,L,L,L,L,Z,A_M1,C0, G_M0,L,L,A_M0,C0, L,L,Z, L,L,Z};
    run(cur, "burst_m0drop");
    cur = '{L,L,L,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};
    run(cur, "burst_idle");

    // Timeout: slave never acks m0; err on the 8th stb cycle, then m1 served.
    cur = '{L,H,H,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};
    run(cur, "to_req");
    for (int i = 1; i <= 7; i++) begin
      cur = '{L,H,H,H,H,L,Z,A_M1,C0, G_M0,H,H,A_M0,C0, L,L,Z, L,L,Z};
      run(cur, $sformatf("to_wait%0d", i));
    end
    cur = '{L,H,H,H,H,L,Z,A_M1,C0, G_M0,L,L,A_M0,C0, L,H,Z, L,L,Z};
    run(cur, "to_err");
    cur = '{L,H,H,H,H,L,Z,A_M1,C0, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};
    run(cur, "to_idle");
    cur = '{L,L,L,H,H,L,Z,A_M1,C0, G_M1,H,H,A_M1,C0, L,L,Z, L,L,Z};
    run(cur, "to_m1gnt");
    cur = '{L,L,L,L,L,L,Z,A_M1,C0, G_M1,L,L,A_M1,C0, L,L,Z, L,L,Z};
    run(cur, "to_m1drop");
    cur = '{L,L,L,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};
    run(cur, "to_done");

    // Ack exactly on the timeout cycle: ack wins, no err.
    cur = '{L,H,H,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};
    run(cur, "tb_req");
    for (int i = 1; i <= 7; i++) begin
      cur = '{L,H,H,L,L,L,Z,A_M1,C0, G_M0,H,H,A_M0,C0, L,L,Z, L,L,Z};
      run(cur, $sformatf("tb_wait%0d", i));
    end
    cur = '{L,H,H,L,L,H,32'hCAFEF00D,A_M1,C0, G_M0,H,H,A_M0,C0, H,L,32'hCAFEF00D, L,L,Z};
    run(cur, "tb_ack");
    cur = '{L,L,L,L,L,L,Z,A_M1,C0, G_M0,L,L,A_M0,C0, L,L,Z, L,L,Z};
    run(cur, "tb_drop");
    cur = '{L,L,L,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};
    run(cur, "tb_idle");

    // Reset during beat 2 of an m1 write burst.
    cur = '{L,L,L,H,H,L,Z,A_M1,CI, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};
    run(cur, "rst_req");
    cur = '{L,L,L,H,H,H,32'h2000,A_M1,CI, G_M1,H,H,A_M1,CI, L,L,Z, H,L,32'h2000};
    run(cur, "rst_beat1");
    cur = '{H,L,L,H,H,L,Z,32'h204,CI, G_M1,H,H,32'h204,CI, L,L,Z, L,L,Z};
    run(cur, "rst_beat2");
    cur = '{L,H,H,H,H,H,32'h3000,32'h204,CI, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};
    run(cur, "rst_after");
    cur = '{L,H,H,H,H,L,Z,32'h204,CI, G_M0,H,H,A_M0,C0, L,L,Z, L,L,Z};
    run(cur, "rst_tie");
    cur = '{L,L,L,L,L,L,Z,A_M1,C0, G_M0,L,L,A_M0,C0, L,L,Z, L,L,Z};
    run(cur, "rst_drop");
    cur = '{L,L,L,L,L,L,Z,A_M1,C0, G_ID,L,L,Z,C0, L,L,Z, L,L,Z};
    run(cur, "rst_idle");

    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
